// File: rtl/conv_pkg.sv
// Shared helpers for the streaming KxK convolution: width math and the
// accumulator-to-pixel rescale with saturation.
package conv_pkg;

    // Widest accumulator the rescale helper accepts.
    localparam int MAX_ACC_W = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int acc_w(input int data_width, input int k);
        return 2 * data_width + clog2(k * k);
    endfunction

    // Arithmetic shift (floor) followed by clamp to the signed data_width range.
    function automatic logic signed [MAX_ACC_W-1:0] sat_shift(
        input logic signed [MAX_ACC_W-1:0] acc,
        input int                          frac_bits,
        input int                          data_width
    );
        logic signed [MAX_ACC_W-1:0] shifted;
        logic signed [MAX_ACC_W-1:0] max_val;
        logic signed [MAX_ACC_W-1:0] min_val;
        shifted = acc >>> frac_bits;
        max_val = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (data_width - 1));
        if (shifted > max_val) begin
            return max_val;
        end else if (shifted < min_val) begin
            return min_val;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: a DEPTH-entry enabled shift register, no reset
// because its contents are only ever observed after being refilled.
module conv_line_buffer #(
    parameter int DEPTH      = 220,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Shift one entry per accepted pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming signed fixed-point KxK convolution with line buffers, stride,
// per-frame kernel latch, rescale/saturation and end-of-frame marker.
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int K          = 3,
    parameter int IMG_W      = 220,
    parameter int IMG_H      = 220,
    parameter int STRIDE     = 1,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   in_pixel,
    input  logic [K*K*DATA_WIDTH-1:0]      kernel_flat,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   out_pixel,
    output logic                           out_last
);

    localparam int KK    = K * K;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = acc_w(DATA_WIDTH, K);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int CW    = clog2(IMG_W + 1);
    localparam int RW    = clog2(IMG_H + 1);
    localparam int SW    = clog2(STRIDE + 1);
    localparam int OCW   = clog2(OUT_W + 1);
    localparam int ORW   = clog2(OUT_H + 1);

    logic                          adv_s;
    logic                          accept_s;
    logic [CW-1:0]                 col_r;
    logic [RW-1:0]                 row_r;
    logic [SW-1:0]                 scol_r;
    logic [SW-1:0]                 srow_r;
    logic [SW-1:0]                 scol_next_s;
    logic [SW-1:0]                 srow_next_s;
    logic [OCW-1:0]                ocol_r;
    logic [ORW-1:0]                orow_r;
    logic                          col_wrap_s;
    logic                          row_wrap_s;
    logic                          win_ok_s;
    logic                          win_last_s;
    logic [DATA_WIDTH-1:0]         lb_din_s   [K-1];
    logic [DATA_WIDTH-1:0]         lb_dout_s  [K-1];
    logic signed [DATA_WIDTH-1:0]  column_s   [K];
    logic signed [DATA_WIDTH-1:0]  win_r      [KK];
    logic signed [DATA_WIDTH-1:0]  kern_s     [KK];
    logic [KK*DATA_WIDTH-1:0]      kernel_r;
    logic                          s1_valid_r;
    logic                          s1_last_r;
    logic                          s2_valid_r;
    logic                          s2_last_r;
    logic signed [PW-1:0]          prod_r     [KK];
    logic signed [ACC_W-1:0]       acc_s;
    logic signed [DATA_WIDTH-1:0]  res_s;

    // Full stall: nothing moves while a result waits on downstream.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s && !reset;
    assign accept_s = in_valid && in_ready;

    // Line buffers are chained: buffer i holds the row i+1 above the current one.
    always_comb begin
        lb_din_s[0] = in_pixel;
        for (int i = 1; i < K - 1; i++) begin
            lb_din_s[i] = lb_dout_s[i-1];
        end
    end

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        conv_line_buffer #(
            .DEPTH      (IMG_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lb (
            .clk  (clk),
            .en   (accept_s),
            .din  (lb_din_s[g]),
            .dout (lb_dout_s[g])
        );
    end

    // New right-hand window column: bottom row is the incoming pixel.
    always_comb begin
        column_s[K-1] = in_pixel;
        for (int i = 0; i < K - 1; i++) begin
            column_s[K-2-i] = lb_dout_s[i];
        end
    end

    // Position decode and stride phase for the pixel being offered.
    always_comb begin
        col_wrap_s = (col_r == CW'(IMG_W - 1));
        row_wrap_s = (row_r == RW'(IMG_H - 1));
        win_ok_s   = (col_r >= CW'(K - 1)) && (row_r >= RW'(K - 1)) &&
                     (scol_r == {SW{1'b0}}) && (srow_r == {SW{1'b0}});
        win_last_s = win_ok_s && (ocol_r == OCW'(OUT_W - 1)) &&
                     (orow_r == ORW'(OUT_H - 1));
        if (col_r < CW'(K - 1)) begin
            scol_next_s = {SW{1'b0}};
        end else if (scol_r == SW'(STRIDE - 1)) begin
            scol_next_s = {SW{1'b0}};
        end else begin
            scol_next_s = scol_r + SW'(1);
        end
        if (row_r < RW'(K - 1)) begin
            srow_next_s = {SW{1'b0}};
        end else if (srow_r == SW'(STRIDE - 1)) begin
            srow_next_s = {SW{1'b0}};
        end else begin
            srow_next_s = srow_r + SW'(1);
        end
    end

    // Raster, stride-phase and output-position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r  <= {CW{1'b0}};
            row_r  <= {RW{1'b0}};
            scol_r <= {SW{1'b0}};
            srow_r <= {SW{1'b0}};
            ocol_r <= {OCW{1'b0}};
            orow_r <= {ORW{1'b0}};
        end else if (accept_s) begin
            if (col_wrap_s) begin
                col_r  <= {CW{1'b0}};
                scol_r <= {SW{1'b0}};
                if (row_wrap_s) begin
                    row_r  <= {RW{1'b0}};
                    srow_r <= {SW{1'b0}};
                end else begin
                    row_r  <= row_r + RW'(1);
                    srow_r <= srow_next_s;
                end
            end else begin
                col_r  <= col_r + CW'(1);
                scol_r <= scol_next_s;
            end
            if (win_ok_s) begin
                if (ocol_r == OCW'(OUT_W - 1)) begin
                    ocol_r <= {OCW{1'b0}};
                    if (orow_r == ORW'(OUT_H - 1)) begin
                        orow_r <= {ORW{1'b0}};
                    end else begin
                        orow_r <= orow_r + ORW'(1);
                    end
                end else begin
                    ocol_r <= ocol_r + OCW'(1);
                end
            end
        end
    end

    // Window shift and per-frame kernel capture on the first pixel of a frame.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_r[r*K+c] <= win_r[r*K+c+1];
                end
                win_r[r*K+K-1] <= column_s[r];
            end
            if ((col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}})) begin
                kernel_r <= kernel_flat;
            end
        end
    end

    // Unpack latched coefficients.
    always_comb begin
        for (int i = 0; i < KK; i++) begin
            kern_s[i] = kernel_r[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Product stage.
    always_ff @(posedge clk) begin
        if (adv_s) begin
            for (int i = 0; i < KK; i++) begin
                prod_r[i] <= PW'(win_r[i]) * PW'(kern_s[i]);
            end
        end
    end

    // Sum of products, rescale and clamp.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int i = 0; i < KK; i++) begin
            acc_s = acc_s + ACC_W'(prod_r[i]);
        end
        res_s = DATA_WIDTH'(sat_shift(MAX_ACC_W'(acc_s), FRAC_BITS, DATA_WIDTH));
    end

    // Valid/last pipeline and registered outputs; frozen during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_pixel  <= {DATA_WIDTH{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= accept_s && win_ok_s;
            s1_last_r  <= accept_s && win_last_s;
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            out_valid  <= s2_valid_r;
            out_last   <= s2_valid_r && s2_last_r;
            if (s2_valid_r) begin
                out_pixel <= res_s;
            end
        end
    end

endmodule
